// File: rtl/risk_pkg.sv
// Shared types for the pre-trade risk checker: FSM states, decision reason codes, default widths.
package risk_pkg;

    localparam int DEF_D_WIDTH  = 32;
    localparam int DEF_A_WIDTH  = 10;
    localparam int DEF_CLIENT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CHK  = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RSN_OK       = 2'd0,
        RSN_LIMIT    = 2'd1,
        RSN_OVERFLOW = 2'd2,
        RSN_ZERO_QTY = 2'd3
    } reason_t;

endpackage

// File: rtl/order_risk_check_if.sv
// Order, limit-update and decision handshakes between the host side and the risk checker.
interface order_risk_check_if #(
    parameter int D_WIDTH  = 32,
    parameter int CLIENT_W = 5
);
    logic                ord_valid;
    logic                ord_ready;
    logic [CLIENT_W-1:0] ord_client;
    logic [D_WIDTH-1:0]  ord_qty;

    logic                max_valid;
    logic                max_ready;
    logic [CLIENT_W-1:0] max_client;
    logic [D_WIDTH-1:0]  max_value;

    logic                res_valid;
    logic                res_ready;
    logic [CLIENT_W-1:0] res_client;
    logic                res_accept;
    logic [1:0]          res_reason;
    logic [D_WIDTH-1:0]  res_new_acc;

    modport master (
        output ord_valid, ord_client, ord_qty,
        output max_valid, max_client, max_value,
        output res_ready,
        input  ord_ready, max_ready,
        input  res_valid, res_client, res_accept, res_reason, res_new_acc
    );

    modport slave (
        input  ord_valid, ord_client, ord_qty,
        input  max_valid, max_client, max_value,
        input  res_ready,
        output ord_ready, max_ready,
        output res_valid, res_client, res_accept, res_reason, res_new_acc
    );
endinterface

// File: rtl/risk_limit_cmp.sv
// Combinational limit decision: acc+qty against max, with zero-qty and carry-out rejects.
module risk_limit_cmp
    import risk_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input  logic [D_WIDTH-1:0] acc,
    input  logic [D_WIDTH-1:0] qty,
    input  logic [D_WIDTH-1:0] max_val,
    output logic               accept,
    output reason_t            reason,
    output logic [D_WIDTH-1:0] sum
);
    logic [D_WIDTH:0] sum_full;

    assign sum_full = {1'b0, acc} + {1'b0, qty};
    assign sum      = sum_full[D_WIDTH-1:0];

    // Carry-out is tested before the limit so a wrapped sum can never look small.
    always_comb begin
        reason = RSN_OK;
        if (qty == '0)
            reason = RSN_ZERO_QTY;
        else if (sum_full[D_WIDTH])
            reason = RSN_OVERFLOW;
        else if (sum_full[D_WIDTH-1:0] > max_val)
            reason = RSN_LIMIT;
    end

    assign accept = (reason == RSN_OK);
endmodule

// File: rtl/order_risk_check.sv
// Pre-trade limit checker driving the per-client limit RAM; one order in flight at a time.
// Optional decision counters are built when RISK_STATS_EN is defined.
module order_risk_check
    import risk_pkg::*;
#(
    parameter int D_WIDTH  = DEF_D_WIDTH,
    parameter int A_WIDTH  = DEF_A_WIDTH,
    parameter int CLIENT_W = DEF_CLIENT_W
) (
    input  logic                clk,
    input  logic                rst,
    order_risk_check_if.slave   bus,
    output logic [A_WIDTH-1:0]  ram_address_write,
    output logic [D_WIDTH-1:0]  ram_data_write,
    output logic                ram_write_enable,
    output logic                ram_change_max,
    output logic [A_WIDTH-1:0]  ram_address_read,
    input  logic [D_WIDTH-1:0]  ram_accumulated_orders,
    input  logic [D_WIDTH-1:0]  ram_max_to_trade,
    output logic [31:0]         stat_accept_cnt,
    output logic [31:0]         stat_reject_cnt
);
    localparam int PAD_W = A_WIDTH - CLIENT_W;

    state_t              state_reg, state_next;
    logic [CLIENT_W-1:0] client_reg;
    logic [D_WIDTH-1:0]  qty_reg;
    logic                res_valid_reg, res_accept_reg;
    logic [CLIENT_W-1:0] res_client_reg;
    reason_t             res_reason_reg;
    logic [D_WIDTH-1:0]  res_new_acc_reg;

    logic                max_ready_next, ord_ready_next, we_next, cm_next;
    logic [A_WIDTH-1:0]  waddr_next, raddr_next;
    logic [D_WIDTH-1:0]  wdata_next;

    logic                cmp_accept;
    reason_t             cmp_reason;
    logic [D_WIDTH-1:0]  cmp_sum;

    risk_limit_cmp #(.D_WIDTH(D_WIDTH)) u_cmp (
        .acc     (ram_accumulated_orders),
        .qty     (qty_reg),
        .max_val (ram_max_to_trade),
        .accept  (cmp_accept),
        .reason  (cmp_reason),
        .sum     (cmp_sum)
    );

    always_comb begin
        state_next     = state_reg;
        max_ready_next = 1'b0;
        ord_ready_next = 1'b0;
        we_next        = 1'b0;
        cm_next        = 1'b0;
        waddr_next     = '0;
        wdata_next     = '0;
        raddr_next     = '0;
        case (state_reg)
            IDLE: begin
                max_ready_next = 1'b1;
                if (bus.max_valid) begin
                    we_next    = 1'b1;
                    cm_next    = 1'b1;
                    waddr_next = {{PAD_W{1'b0}}, bus.max_client};
                    wdata_next = bus.max_value;
                end else begin
                    ord_ready_next = 1'b1;
                    if (bus.ord_valid)
                        state_next = RD;
                end
            end
            RD: begin
                raddr_next = {{PAD_W{1'b0}}, client_reg};
                state_next = CHK;
            end
            CHK: begin
                if (cmp_accept) begin
                    we_next    = 1'b1;
                    waddr_next = {{PAD_W{1'b0}}, client_reg};
                    wdata_next = cmp_sum;
                end
                state_next = RESP;
            end
            RESP: begin
                if (bus.res_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset masks the handshakes and the write strobe in the cycle it is asserted.
    assign bus.max_ready     = max_ready_next & ~rst;
    assign bus.ord_ready     = ord_ready_next & ~rst;
    assign ram_write_enable  = we_next & ~rst;
    assign ram_change_max    = cm_next & ~rst;
    assign ram_address_write = waddr_next;
    assign ram_data_write    = wdata_next;
    assign ram_address_read  = raddr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            client_reg      <= '0;
            qty_reg         <= '0;
            res_valid_reg   <= 1'b0;
            res_client_reg  <= '0;
            res_accept_reg  <= 1'b0;
            res_reason_reg  <= RSN_OK;
            res_new_acc_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && !bus.max_valid && bus.ord_valid) begin
                client_reg <= bus.ord_client;
                qty_reg    <= bus.ord_qty;
            end
            if (state_reg == CHK) begin
                res_valid_reg   <= 1'b1;
                res_client_reg  <= client_reg;
                res_accept_reg  <= cmp_accept;
                res_reason_reg  <= cmp_reason;
                res_new_acc_reg <= cmp_accept ? cmp_sum : ram_accumulated_orders;
            end
            if (state_reg == RESP && bus.res_ready)
                res_valid_reg <= 1'b0;
        end
    end

    assign bus.res_valid   = res_valid_reg;
    assign bus.res_client  = res_client_reg;
    assign bus.res_accept  = res_accept_reg;
    assign bus.res_reason  = res_reason_reg;
    assign bus.res_new_acc = res_new_acc_reg;

`ifdef RISK_STATS_EN
    logic [31:0] acc_cnt_reg, rej_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt_reg <= '0;
            rej_cnt_reg <= '0;
        end else if (state_reg == CHK) begin
            if (cmp_accept && acc_cnt_reg != 32'hFFFF_FFFF)
                acc_cnt_reg <= acc_cnt_reg + 32'd1;
            if (!cmp_accept && rej_cnt_reg != 32'hFFFF_FFFF)
                rej_cnt_reg <= rej_cnt_reg + 32'd1;
        end
    end

    assign stat_accept_cnt = acc_cnt_reg;
    assign stat_reject_cnt = rej_cnt_reg;
`else
    assign stat_accept_cnt = 32'd0;
    assign stat_reject_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_order_risk_check.sv
// Directed bench for order_risk_check with a 1-clk registered-read model of the limit RAM.
module tb_order_risk_check;
    import risk_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  ram_address_write, ram_address_read;
    logic [31:0] ram_data_write, ram_acc_q, ram_max_q;
    logic        ram_write_enable, ram_change_max;
    logic [31:0] stat_accept_cnt, stat_reject_cnt;

    logic [31:0] acc_mem [0:1023];
    logic [31:0] max_mem [0:1023];
    int          wr_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    int          exp_acc_cnt = 0;
    int          exp_rej_cnt = 0;

    order_risk_check_if #(.D_WIDTH(32), .CLIENT_W(5)) bus ();

    order_risk_check #(.D_WIDTH(32), .A_WIDTH(10), .CLIENT_W(5)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .bus                    (bus.slave),
        .ram_address_write      (ram_address_write),
        .ram_data_write         (ram_data_write),
        .ram_write_enable       (ram_write_enable),
        .ram_change_max         (ram_change_max),
        .ram_address_read       (ram_address_read),
        .ram_accumulated_orders (ram_acc_q),
        .ram_max_to_trade       (ram_max_q),
        .stat_accept_cnt        (stat_accept_cnt),
        .stat_reject_cnt        (stat_reject_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_acc_q <= acc_mem[ram_address_read];
        ram_max_q <= max_mem[ram_address_read];
        if (ram_write_enable) begin
            wr_cnt <= wr_cnt + 1;
            if (ram_change_max) max_mem[ram_address_write] <= ram_data_write;
            else                acc_mem[ram_address_write] <= ram_data_write;
        end
    end

    typedef struct {
        bit          is_max;
        logic [4:0]  client;
        logic [31:0] value;
        logic        exp_accept;
        logic [1:0]  exp_reason;
        logic [31:0] exp_acc;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_max(input logic [4:0] c, input logic [31:0] v);
        int n = 0;
        bus.max_valid = 1'b1; bus.max_client = c; bus.max_value = v;
        @(negedge clk);
        while (!bus.max_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("max_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.max_valid = 1'b0;
    endtask

    task automatic send_order(input logic [4:0] c, input logic [31:0] q);
        int n = 0;
        bus.ord_valid = 1'b1; bus.ord_client = c; bus.ord_qty = q;
        @(negedge clk);
        while (!bus.ord_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("ord_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.ord_valid = 1'b0;
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.res_valid && lat < 50);
        if (!bus.res_valid) chk("res_valid_timeout", 0, 1);
    endtask

    task automatic finish_res();
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    initial begin
        int lat, w0;
        logic [31:0] exp_a, exp_r;
        for (int i = 0; i < 1024; i++) begin acc_mem[i] = '0; max_mem[i] = '0; end
        acc_mem[7] = 32'hFFFF_FFF0;
        bus.ord_valid = 0; bus.ord_client = 0; bus.ord_qty = 0;
        bus.max_valid = 0; bus.max_client = 0; bus.max_value = 0;
        bus.res_ready = 0;

        vecs[0] = '{1, 5'd3,  32'd100,         0, RSN_OK,       32'd0};
        vecs[1] = '{0, 5'd3,  32'd40,          1, RSN_OK,       32'd40};
        vecs[2] = '{0, 5'd3,  32'd60,          1, RSN_OK,       32'd100};
        vecs[3] = '{0, 5'd3,  32'd1,           0, RSN_LIMIT,    32'd100};
        vecs[4] = '{0, 5'd3,  32'd0,           0, RSN_ZERO_QTY, 32'd100};
        vecs[5] = '{1, 5'd7,  32'hFFFF_FFFF,   0, RSN_OK,       32'd0};
        vecs[6] = '{0, 5'd7,  32'h20,          0, RSN_OVERFLOW, 32'hFFFF_FFF0};
        vecs[7] = '{0, 5'd7,  32'hF,           1, RSN_OK,       32'hFFFF_FFFF};
        vecs[8] = '{0, 5'd9,  32'd5,           0, RSN_LIMIT,    32'd0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_res_valid", bus.res_valid, 0);
        chk("reset_res_fields", {bus.res_client, bus.res_accept, bus.res_reason, bus.res_new_acc}, 0);
        chk("reset_ord_ready", bus.ord_ready, 1);
        chk("reset_max_ready", bus.max_ready, 1);
        chk("reset_ram_we", ram_write_enable, 0);
        chk("reset_stats", {stat_accept_cnt, stat_reject_cnt}, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            w0 = wr_cnt;
            if (vecs[i].is_max) begin
                send_max(vecs[i].client, vecs[i].value);
                chk("max_written", max_mem[vecs[i].client], vecs[i].value);
                chk("max_wr_count", wr_cnt - w0, 1);
                $display("vec %0d: max c%0d=%0h", i, vecs[i].client, vecs[i].value);
            end else begin
                send_order(vecs[i].client, vecs[i].value);
                wait_res(lat);
                chk("latency", lat, 3);
                chk("res_client", bus.res_client, vecs[i].client);
                chk("res_accept", bus.res_accept, vecs[i].exp_accept);
                chk("res_reason", bus.res_reason, vecs[i].exp_reason);
                chk("res_new_acc", bus.res_new_acc, vecs[i].exp_acc);
                $display("vec %0d: order c%0d qty=%0h -> acc=%0b rsn=%0d new_acc=%0h", i,
                         vecs[i].client, vecs[i].value, bus.res_accept, bus.res_reason, bus.res_new_acc);
                finish_res();
                chk("order_wr_count", wr_cnt - w0, vecs[i].exp_accept ? 1 : 0);
                chk("ram_acc", acc_mem[vecs[i].client], vecs[i].exp_acc);
                if (vecs[i].exp_accept) exp_acc_cnt++; else exp_rej_cnt++;
            end
        end

        // Simultaneous update and order: update wins, order sees the new limit.
        bus.max_valid = 1; bus.max_client = 5'd11; bus.max_value = 32'd50;
        bus.ord_valid = 1; bus.ord_client = 5'd11; bus.ord_qty = 32'd50;
        @(negedge clk);
        chk("prio_ord_ready", bus.ord_ready, 0);
        chk("prio_max_ready", bus.max_ready, 1);
        chk("prio_change_max", {ram_write_enable, ram_change_max}, 2'b11);
        @(posedge clk); #1;
        bus.max_valid = 0;
        @(negedge clk);
        chk("prio_ord_ready_next", bus.ord_ready, 1);
        @(posedge clk); #1;
        bus.ord_valid = 0;
        wait_res(lat);
        chk("prio_latency", lat, 3);
        chk("prio_accept", {bus.res_accept, bus.res_reason}, {1'b1, RSN_OK});
        chk("prio_new_acc", bus.res_new_acc, 32'd50);
        $display("prio: order c11 qty=50 -> acc=%0b new_acc=%0h", bus.res_accept, bus.res_new_acc);
        finish_res();
        chk("prio_max_mem", max_mem[11], 32'd50);
        exp_acc_cnt++;

        // Backpressure on the decision: outputs hold, no new order taken.
        w0 = wr_cnt;
        send_order(5'd11, 32'd1);
        wait_res(lat);
        bus.ord_valid = 1; bus.ord_client = 5'd3; bus.ord_qty = 32'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_res_valid", bus.res_valid, 1);
            chk("hold_res_fields", {bus.res_client, bus.res_accept, bus.res_reason, bus.res_new_acc},
                {5'd11, 1'b0, RSN_LIMIT, 32'd50});
            chk("hold_ord_ready", bus.ord_ready, 0);
        end
        $display("hold: order c11 qty=1 held 5 clks rsn=%0d", bus.res_reason);
        bus.ord_valid = 0;
        finish_res();
        chk("hold_wr_count", wr_cnt - w0, 0);
        @(negedge clk);
        chk("hold_back_idle", {bus.ord_ready, bus.res_valid}, 2'b10);
        @(posedge clk); #1;
        exp_rej_cnt++;

`ifdef RISK_STATS_EN
        exp_a = exp_acc_cnt; exp_r = exp_rej_cnt;
`else
        exp_a = 0; exp_r = 0;
`endif
        chk("stat_accept", stat_accept_cnt, exp_a);
        chk("stat_reject", stat_reject_cnt, exp_r);

        // Reset while an accepting order is in CHK.
        send_max(5'd12, 32'd10);
        w0 = wr_cnt;
        send_order(5'd12, 32'd4);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_no_we", ram_write_enable, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_res_valid", bus.res_valid, 0);
        end
        chk("rst_idle", bus.ord_ready, 1);
        chk("rst_wr_count", wr_cnt - w0, 0);
        chk("rst_acc_mem", acc_mem[12], 0);
        chk("rst_stats", {stat_accept_cnt, stat_reject_cnt}, 0);
        $display("rst: order c12 qty=4 aborted in CHK, acc_mem=%0h", acc_mem[12]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
